// File: rtl/ace_rle_pkg.sv
// Shared constants and state encoding for the Jupiter Ace .ACE snapshot packer.
// The escape byte introduces either a run triple (ESC n v) or the stream end (ESC 00).
package ace_rle_pkg;

    localparam logic [7:0] ESC  = 8'hED;
    localparam logic [7:0] TERM = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_EMIT_LIT,
        ST_EMIT_ESC,
        ST_EMIT_CNT,
        ST_EMIT_VAL,
        ST_TERM_ESC,
        ST_TERM_ZERO
    } state_t;

    // A literal ESC byte must always travel inside a triple, or the loader would misparse it.
    function automatic logic needs_escape(input logic [7:0] val,
                                          input logic [7:0] n,
                                          input logic [7:0] min_run);
        return (n >= min_run) || (val == ESC);
    endfunction

endpackage

// File: rtl/ace_rle_encoder.sv
// Reads a block of Ace RAM and streams it out in .ACE run-length escape format,
// one byte per ready/valid handshake, closing the stream with ESC 00.
module ace_rle_encoder
    import ace_rle_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter int          MIN_RUN   = 4,
    parameter int          MAX_RUN   = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] len,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] MIN_RUN_B = 8'(MIN_RUN);
    localparam logic [7:0] MAX_RUN_B = 8'(MAX_RUN);

    state_t      state;
    logic [7:0]  cur;
    logic [7:0]  nxt;
    logic [7:0]  run_cnt;
    logic [7:0]  lit_left;
    logic [15:0] remain;
    logic        pending;

    logic [7:0]  run_val;
    logic [7:0]  run_len;
    logic        run_break;
    logic        fire;
    logic        flush_end;

    // Decide what the freshly read byte does to the current run.
    always_comb begin
        run_val   = cur;
        run_len   = run_cnt;
        run_break = 1'b0;
        if (run_cnt == 8'd0) begin
            run_val = mem_data;
            run_len = 8'd1;
        end else if (mem_data == cur && run_cnt < MAX_RUN_B) begin
            run_len = run_cnt + 8'd1;
        end else begin
            run_break = 1'b1;
        end
    end

    assign fire      = out_valid & out_ready;
    assign flush_end = fire && ((state == ST_EMIT_LIT && lit_left == 8'd1) ||
                                state == ST_EMIT_VAL);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur       <= 8'd0;
            nxt       <= 8'd0;
            run_cnt   <= 8'd0;
            lit_left  <= 8'd0;
            remain    <= 16'd0;
            pending   <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_rd    <= 1'b0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !busy) begin
                        remain   <= len;
                        mem_addr <= BASE_ADDR;
                        busy     <= 1'b1;
                        run_cnt  <= 8'd0;
                        pending  <= 1'b0;
                        if (len != 16'd0) begin
                            state  <= ST_READ;
                            mem_rd <= 1'b1;
                        end else begin
                            state     <= ST_TERM_ESC;
                            out_data  <= ESC;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    mem_rd   <= 1'b0;
                    mem_addr <= mem_addr + 16'd1;
                    remain   <= remain - 16'd1;
                    state    <= ST_LATCH;
                end
                ST_LATCH: begin
                    cur     <= run_val;
                    run_cnt <= run_len;
                    if (run_break) begin
                        nxt     <= mem_data;
                        pending <= 1'b1;
                    end
                    if (!run_break && remain != 16'd0) begin
                        state  <= ST_READ;
                        mem_rd <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                        if (needs_escape(run_val, run_len, MIN_RUN_B)) begin
                            state    <= ST_EMIT_ESC;
                            out_data <= ESC;
                        end else begin
                            state    <= ST_EMIT_LIT;
                            out_data <= run_val;
                            lit_left <= run_len;
                        end
                    end
                end
                ST_EMIT_LIT: begin
                    if (fire && lit_left != 8'd1)
                        lit_left <= lit_left - 8'd1;
                end
                ST_EMIT_ESC: begin
                    if (fire) begin
                        out_data <= run_cnt;
                        state    <= ST_EMIT_CNT;
                    end
                end
                ST_EMIT_CNT: begin
                    if (fire) begin
                        out_data <= cur;
                        state    <= ST_EMIT_VAL;
                    end
                end
                ST_EMIT_VAL: begin
                end
                ST_TERM_ESC: begin
                    if (fire) begin
                        out_data <= TERM;
                        state    <= ST_TERM_ZERO;
                    end
                end
                ST_TERM_ZERO: begin
                    if (fire) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A finished run either promotes the held-back byte to a new run or closes the stream.
            if (flush_end) begin
                if (pending) begin
                    pending <= 1'b0;
                    cur     <= nxt;
                    run_cnt <= 8'd1;
                    if (remain != 16'd0) begin
                        out_valid <= 1'b0;
                        state     <= ST_READ;
                        mem_rd    <= 1'b1;
                    end else if (needs_escape(nxt, 8'd1, MIN_RUN_B)) begin
                        state    <= ST_EMIT_ESC;
                        out_data <= ESC;
                    end else begin
                        state    <= ST_EMIT_LIT;
                        out_data <= nxt;
                        lit_left <= 8'd1;
                    end
                end else begin
                    state    <= ST_TERM_ESC;
                    out_data <= ESC;
                end
            end
        end
    end

endmodule
